kamacore_stage_id: RTL and testbench
====================================

Name: kamacore_stage_id

Overview:
Instruction Decode stage. It is the consumer end of the IF/ID pipeline register, which the fetch stage drives with instruction, PC and valid each cycle. The stage decodes the RV32I base subset, reads operands from an internal register file, and detects load-use hazards, stalling fetch when one occurs. It registers decoded fields into the ID/EX pipeline register for the execute stage.

Parameters:
CPU_WIDTH, 32, datapath/instruction width (package constant, not overridden)
ADDR_WIDTH, package value, word-addressed PC width
REG_COUNT, 32, architectural registers; x0 hard-wired zero

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
branch_valid  in  1  taken branch/jump resolved in EX; flush ID
if_valid  in  1  IF/ID slot holds a real instruction
if_instruction  in  CPU_WIDTH  fetched instruction
if_pc  in  ADDR_WIDTH  PC of fetched instruction
stall_if  out  1  combinational; IF must hold PC and IF/ID this cycle
wb_we  in  1  write-back enable
wb_rd  in  5  write-back register index
wb_data  in  CPU_WIDTH  write-back data
id_ex_valid  out  1  ID/EX slot valid
id_ex_pc  out  ADDR_WIDTH  instruction PC
id_ex_rs1_data, id_ex_rs2_data  out  CPU_WIDTH  operands
id_ex_rs1, id_ex_rs2, id_ex_rd  out  5  register indices
id_ex_imm  out  CPU_WIDTH  sign-extended immediate
id_ex_alu_op  out  4  alu_op_t
id_ex_funct3  out  3  funct3 (branch condition / load-store size)
id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_branch, id_ex_jump, id_ex_illegal  out  1 each  control flags

Behaviour:
- All id_ex_* outputs are registered with 1-cycle latency. Reset (rst==0 at a clock edge) zeroes all id_ex_* outputs and clears every register-file entry.
- Priority at each edge: reset > flush (branch_valid) > stall > normal.
- Normal operation: id_ex_* <= decode(if_instruction), id_ex_valid <= if_valid.
- Flush: when branch_valid==1, id_ex_valid <= 0 and all control flags <= 0, whether or not a stall is pending. stall_if is forced to 0 during a flush.
- Load-use hazard (combinational): id_ex_valid && id_ex_mem_read && id_ex_rd!=0 && if_valid && ((uses_rs1 && rs1==id_ex_rd) || (uses_rs2 && rs2==id_ex_rd)).
  - When the hazard is set: stall_if=1, a bubble is inserted (id_ex_valid<=0, flags 0), and IF/ID is held upstream.
  - The stall lasts exactly 1 cycle, because the bubble clears the condition.
- uses_rs1: all formats except U and J. uses_rs2: R, S and B formats.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to CPU_WIDTH. EX owns any byte/word PC scaling.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode sets id_ex_illegal=1 with reg_write, mem_read and mem_write all 0; valid still propagates.
- Register file:
  - 2 asynchronous read ports, 1 synchronous write port.
  - Write occurs at the edge when wb_we && wb_rd!=0. Writes to x0 are ignored, and x0 always reads 0.
  - Same-cycle bypass: if wb_we && wb_rd!=0 and wb_rd equals a read index, that read returns wb_data.
- Register-file writes proceed during stall and flush.
- A reset asserted mid-stall clears the stall state; stall_if is 0 in the first cycle after reset.

Decomposition:
- kamacore_pkg:
  - CPU_WIDTH, ADDR_WIDTH, REG_COUNT.
  - opcode_t enum (7-bit RV32I opcodes).
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - imm_fmt_t enum: I, S, B, U, J, NONE.
- Sub-module kamacore_regfile: parameterised on REG_COUNT/CPU_WIDTH, with 2R1W and write-first bypass.
- Decode logic stays in an always_comb inside the stage.

Test Plan:
- ADDI x1,x0,5 (0x00500093), if_valid=1 -> next cycle: id_ex_valid=1, rd=1, rs1=0, imm=5, alu_src_imm=1, reg_write=1, alu_op=ADD.
- LW x2,0(x1) (0x0000A103), then ADD x3,x2,x1 (0x001101B3) -> stall_if=1 for exactly 1 cycle; one bubble (id_ex_valid=0); ADD emerges next with rs1=2, rs2=1.
- wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in the same cycle as ADD x6,x5,x0 (0x00028333) -> id_ex_rs1_data=0xDEADBEEF. Separately, wb_rd=0 with wb_data=0x1234 -> a later read of x0 returns 0.
- branch_valid=1 coincident with a load-use hazard -> id_ex_valid=0, stall_if=0, all control flags 0.
- Instruction 0xFFFFFFFF -> id_ex_illegal=1, reg_write=0, mem_write=0, id_ex_valid=1.
- rst=0 asserted mid-stream (during a stall) -> next edge: all id_ex_* outputs 0, stall_if=0, a previously written x1 reads 0.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared constants, enums and decode helpers for the kamacore pipeline.
// Pure declarations; no logic, no latency.
// No flow control.
package kamacore_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int ADDR_WIDTH = 30;
    localparam int REG_COUNT  = 32;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_fmt_t;

    // funct3/funct7[5] to ALU op; funct7[5] selects SUB only for register-register ops,
    // but selects SRA for both shift forms.
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/kamacore_regfile.sv
// Architectural register file: 2 async read ports, 1 sync write port, x0 hard-wired zero.
// Reads are combinational; write lands at the clock edge, with write-first bypass on reads.
// No backpressure; writes are always accepted.
module kamacore_regfile
    import kamacore_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int WIDTH    = CPU_WIDTH,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr1,
    input  logic [IDX_W-1:0] raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wr_en;

    assign wr_en = we && (waddr != '0);

    // Synchronous clear on reset, otherwise commit write-back (x0 never written)
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 is zero, same-cycle write forwards to the reader
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : ((wr_en && waddr == raddr1) ? wdata : regs[raddr1]);
        rdata2 = (raddr2 == '0) ? '0 : ((wr_en && waddr == raddr2) ? wdata : regs[raddr2]);
    end

endmodule

// File: rtl/kamacore_stage_id.sv
// Instruction decode stage: RV32I decode, operand read, load-use hazard detection.
// ID/EX outputs registered, 1-cycle latency; stall_if is combinational.
// Load-use hazard inserts one bubble and holds IF; a branch flush overrides the stall.
module kamacore_stage_id
    import kamacore_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_valid,
    input  logic                  if_valid,
    input  logic [CPU_WIDTH-1:0]  if_instruction,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  stall_if,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [CPU_WIDTH-1:0]  wb_data,
    output logic                  id_ex_valid,
    output logic [ADDR_WIDTH-1:0] id_ex_pc,
    output logic [CPU_WIDTH-1:0]  id_ex_rs1_data,
    output logic [CPU_WIDTH-1:0]  id_ex_rs2_data,
    output logic [4:0]            id_ex_rs1,
    output logic [4:0]            id_ex_rs2,
    output logic [4:0]            id_ex_rd,
    output logic [CPU_WIDTH-1:0]  id_ex_imm,
    output logic [3:0]            id_ex_alu_op,
    output logic [2:0]            id_ex_funct3,
    output logic                  id_ex_alu_src_imm,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_branch,
    output logic                  id_ex_jump,
    output logic                  id_ex_illegal
);

    logic [4:0]           rs1, rs2, rd;
    logic [2:0]           funct3;
    logic [CPU_WIDTH-1:0] rs1_data, rs2_data;
    logic [CPU_WIDTH-1:0] imm;
    imm_fmt_t             fmt;
    alu_op_t              alu_op;
    logic                 alu_src_imm, mem_read, mem_write, reg_write;
    logic                 branch, jump, illegal, uses_rs1, uses_rs2;
    logic                 hazard, bubble;

    assign rs1    = if_instruction[19:15];
    assign rs2    = if_instruction[24:20];
    assign rd     = if_instruction[11:7];
    assign funct3 = if_instruction[14:12];

    kamacore_regfile #(.NUM_REGS(REG_COUNT), .WIDTH(CPU_WIDTH)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Opcode decode into control flags, immediate format and operand usage
    always_comb begin
        fmt         = IMM_NONE;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        illegal     = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (if_instruction[6:0])
            OPC_LUI: begin
                fmt = IMM_U; alu_op = ALU_PASS_B; alu_src_imm = 1'b1; reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; alu_src_imm = 1'b1; reg_write = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J; jump = 1'b1; reg_write = 1'b1;
            end
            OPC_JALR: begin
                fmt = IMM_I; jump = 1'b1; reg_write = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = IMM_B; branch = 1'b1; alu_op = ALU_SUB; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                fmt = IMM_I; mem_read = 1'b1; reg_write = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                fmt = IMM_S; mem_write = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; reg_write = 1'b1; alu_src_imm = 1'b1; uses_rs1 = 1'b1;
                alu_op = alu_from_funct(funct3, if_instruction[30], 1'b0);
            end
            OPC_OP: begin
                reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                alu_op = alu_from_funct(funct3, if_instruction[30], 1'b1);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Immediate assembly and sign extension by format
    always_comb begin
        case (fmt)
            IMM_I:   imm = {{20{if_instruction[31]}}, if_instruction[31:20]};
            IMM_S:   imm = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
            IMM_B:   imm = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                            if_instruction[30:25], if_instruction[11:8], 1'b0};
            IMM_U:   imm = {if_instruction[31:12], 12'b0};
            IMM_J:   imm = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                            if_instruction[20], if_instruction[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Load-use hazard against the load currently in EX; a flush or reset cancels the stall
    always_comb begin
        hazard   = id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) && if_valid &&
                   ((uses_rs1 && rs1 == id_ex_rd) || (uses_rs2 && rs2 == id_ex_rd));
        stall_if = hazard && !branch_valid && rst;
        bubble   = branch_valid || hazard;
    end

    // ID/EX pipeline register: reset > flush > stall bubble > normal decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex_valid       <= 1'b0;
            id_ex_pc          <= '0;
            id_ex_rs1_data    <= '0;
            id_ex_rs2_data    <= '0;
            id_ex_rs1         <= '0;
            id_ex_rs2         <= '0;
            id_ex_rd          <= '0;
            id_ex_imm         <= '0;
            id_ex_alu_op      <= '0;
            id_ex_funct3      <= '0;
            id_ex_alu_src_imm <= 1'b0;
            id_ex_mem_read    <= 1'b0;
            id_ex_mem_write   <= 1'b0;
            id_ex_reg_write   <= 1'b0;
            id_ex_branch      <= 1'b0;
            id_ex_jump        <= 1'b0;
            id_ex_illegal     <= 1'b0;
        end else begin
            id_ex_pc          <= if_pc;
            id_ex_rs1_data    <= rs1_data;
            id_ex_rs2_data    <= rs2_data;
            id_ex_rs1         <= rs1;
            id_ex_rs2         <= rs2;
            id_ex_rd          <= rd;
            id_ex_imm         <= imm;
            id_ex_alu_op      <= alu_op;
            id_ex_funct3      <= funct3;
            id_ex_valid       <= if_valid && !bubble;
            id_ex_alu_src_imm <= alu_src_imm && !bubble;
            id_ex_mem_read    <= mem_read && !bubble;
            id_ex_mem_write   <= mem_write && !bubble;
            id_ex_reg_write   <= reg_write && !bubble;
            id_ex_branch      <= branch && !bubble;
            id_ex_jump        <= jump && !bubble;
            id_ex_illegal     <= illegal && !bubble;
        end
    end

endmodule

// File: tb/tb_kamacore_stage_id.sv
// Directed bench for the decode stage: decode fields, hazards, flush, regfile, reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Each scenario task carries its own inline comparisons.
module tb_kamacore_stage_id;
    import kamacore_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  branch_valid;
    logic                  if_valid;
    logic [CPU_WIDTH-1:0]  if_instruction;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  stall_if;
    logic                  wb_we;
    logic [4:0]            wb_rd;
    logic [CPU_WIDTH-1:0]  wb_data;
    logic                  id_ex_valid;
    logic [ADDR_WIDTH-1:0] id_ex_pc;
    logic [CPU_WIDTH-1:0]  id_ex_rs1_data, id_ex_rs2_data;
    logic [4:0]            id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [CPU_WIDTH-1:0]  id_ex_imm;
    logic [3:0]            id_ex_alu_op;
    logic [2:0]            id_ex_funct3;
    logic                  id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic                  id_ex_branch, id_ex_jump, id_ex_illegal;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    kamacore_stage_id dut (
        .clk               (clk),
        .rst               (rst),
        .branch_valid      (branch_valid),
        .if_valid          (if_valid),
        .if_instruction    (if_instruction),
        .if_pc             (if_pc),
        .stall_if          (stall_if),
        .wb_we             (wb_we),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .id_ex_valid       (id_ex_valid),
        .id_ex_pc          (id_ex_pc),
        .id_ex_rs1_data    (id_ex_rs1_data),
        .id_ex_rs2_data    (id_ex_rs2_data),
        .id_ex_rs1         (id_ex_rs1),
        .id_ex_rs2         (id_ex_rs2),
        .id_ex_rd          (id_ex_rd),
        .id_ex_imm         (id_ex_imm),
        .id_ex_alu_op      (id_ex_alu_op),
        .id_ex_funct3      (id_ex_funct3),
        .id_ex_alu_src_imm (id_ex_alu_src_imm),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_mem_write   (id_ex_mem_write),
        .id_ex_reg_write   (id_ex_reg_write),
        .id_ex_branch      (id_ex_branch),
        .id_ex_jump        (id_ex_jump),
        .id_ex_illegal     (id_ex_illegal)
    );

    localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_LW    = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADD   = 32'h001101B3; // add  x3,x2,x1
    localparam logic [31:0] I_ADD65 = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] I_ADD00 = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] I_ADD31 = 32'h000081B3; // add  x3,x1,x0
    localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_BEQ   = 32'hFE000FE3; // beq  x0,x0,-2
    localparam logic [31:0] I_JAL   = 32'h001000EF; // jal  x1,+2048
    localparam logic [31:0] I_LUI   = 32'h123452B7; // lui  x5,0x12345

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; branch_valid = 1'b0; if_valid = 1'b0; if_instruction = '0; if_pc = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (id_ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", id_ex_valid); else passed++;
        checks++; if (id_ex_imm !== 32'h0) $display("FAIL reset_imm got %h want 0", id_ex_imm); else passed++;
        checks++; if (id_ex_reg_write !== 1'b0) $display("FAIL reset_reg_write got %b want 0", id_ex_reg_write); else passed++;
        checks++; if (stall_if !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_if); else passed++;
    endtask

    task automatic test_addi();
        if_instruction = I_ADDI; if_valid = 1'b1; if_pc = 30'd10;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", id_ex_valid); else passed++;
        checks++; if (id_ex_rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", id_ex_rd); else passed++;
        checks++; if (id_ex_rs1 !== 5'd0) $display("FAIL addi_rs1 got %0d want 0", id_ex_rs1); else passed++;
        checks++; if (id_ex_imm !== 32'd5) $display("FAIL addi_imm got %h want 5", id_ex_imm); else passed++;
        checks++; if (id_ex_alu_src_imm !== 1'b1) $display("FAIL addi_src_imm got %b want 1", id_ex_alu_src_imm); else passed++;
        checks++; if (id_ex_reg_write !== 1'b1) $display("FAIL addi_reg_write got %b want 1", id_ex_reg_write); else passed++;
        checks++; if (id_ex_alu_op !== 4'd0) $display("FAIL addi_alu_op got %0d want 0", id_ex_alu_op); else passed++;
        checks++; if (id_ex_pc !== 30'd10) $display("FAIL addi_pc got %0d want 10", id_ex_pc); else passed++;
    endtask

    task automatic test_load_use();
        if_instruction = I_LW; if_valid = 1'b1; if_pc = 30'd20;
        tick();
        checks++; if (id_ex_mem_read !== 1'b1) $display("FAIL lw_mem_read got %b want 1", id_ex_mem_read); else passed++;
        checks++; if (id_ex_funct3 !== 3'd2) $display("FAIL lw_funct3 got %0d want 2", id_ex_funct3); else passed++;
        if_instruction = I_ADD; if_pc = 30'd21;
        #1;
        checks++; if (stall_if !== 1'b1) $display("FAIL lu_stall_set got %b want 1", stall_if); else passed++;
        tick();
        checks++; if (id_ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %b want 0", id_ex_valid); else passed++;
        checks++; if (id_ex_mem_read !== 1'b0) $display("FAIL lu_bubble_mem_read got %b want 0", id_ex_mem_read); else passed++;
        checks++; if (stall_if !== 1'b0) $display("FAIL lu_stall_clear got %b want 0", stall_if); else passed++;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_valid !== 1'b1) $display("FAIL lu_add_valid got %b want 1", id_ex_valid); else passed++;
        checks++; if (id_ex_rs1 !== 5'd2) $display("FAIL lu_add_rs1 got %0d want 2", id_ex_rs1); else passed++;
        checks++; if (id_ex_rs2 !== 5'd1) $display("FAIL lu_add_rs2 got %0d want 1", id_ex_rs2); else passed++;
        checks++; if (id_ex_rd !== 5'd3) $display("FAIL lu_add_rd got %0d want 3", id_ex_rd); else passed++;
    endtask

    task automatic test_regfile();
        if_instruction = I_ADD65; if_valid = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_we = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'hDEADBEEF) $display("FAIL rf_bypass got %h want deadbeef", id_ex_rs1_data); else passed++;
        checks++; if (id_ex_rs2_data !== 32'h0) $display("FAIL rf_x0_read got %h want 0", id_ex_rs2_data); else passed++;
        tick();
        checks++; if (id_ex_rs1_data !== 32'hDEADBEEF) $display("FAIL rf_stored got %h want deadbeef", id_ex_rs1_data); else passed++;
        if_instruction = I_ADD00;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'h0) $display("FAIL rf_x0_nobypass got %h want 0", id_ex_rs1_data); else passed++;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'h0) $display("FAIL rf_x0_after_write got %h want 0", id_ex_rs1_data); else passed++;
    endtask

    task automatic test_immediates();
        if_valid = 1'b1;
        if_instruction = I_SW;
        tick();
        checks++; if (id_ex_imm !== 32'hFFFFFFFC) $display("FAIL sw_imm got %h want fffffffc", id_ex_imm); else passed++;
        checks++; if (id_ex_mem_write !== 1'b1 || id_ex_reg_write !== 1'b0) $display("FAIL sw_flags got mw=%b rw=%b want mw=1 rw=0", id_ex_mem_write, id_ex_reg_write); else passed++;
        if_instruction = I_BEQ;
        tick();
        checks++; if (id_ex_imm !== 32'hFFFFFFFE) $display("FAIL beq_imm got %h want fffffffe", id_ex_imm); else passed++;
        checks++; if (id_ex_branch !== 1'b1 || id_ex_alu_op !== 4'd1) $display("FAIL beq_ctrl got br=%b op=%0d want br=1 op=1", id_ex_branch, id_ex_alu_op); else passed++;
        if_instruction = I_JAL;
        tick();
        checks++; if (id_ex_imm !== 32'h00000800) $display("FAIL jal_imm got %h want 00000800", id_ex_imm); else passed++;
        checks++; if (id_ex_jump !== 1'b1 || id_ex_reg_write !== 1'b1) $display("FAIL jal_ctrl got j=%b rw=%b want 1 1", id_ex_jump, id_ex_reg_write); else passed++;
        if_instruction = I_LUI;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_imm !== 32'h12345000) $display("FAIL lui_imm got %h want 12345000", id_ex_imm); else passed++;
        checks++; if (id_ex_alu_op !== 4'd10) $display("FAIL lui_alu_op got %0d want 10", id_ex_alu_op); else passed++;
    endtask

    task automatic test_flush_over_stall();
        if_instruction = I_LW; if_valid = 1'b1;
        tick();
        if_instruction = I_ADD; branch_valid = 1'b1;
        #1;
        checks++; if (stall_if !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_if); else passed++;
        tick();
        branch_valid = 1'b0; if_valid = 1'b0;
        checks++; if (id_ex_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", id_ex_valid); else passed++;
        checks++; if ({id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
                       id_ex_branch, id_ex_jump, id_ex_illegal} !== 7'b0)
            $display("FAIL flush_flags got %b want 0000000", {id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write,
                     id_ex_reg_write, id_ex_branch, id_ex_jump, id_ex_illegal});
        else passed++;
    endtask

    task automatic test_illegal();
        if_instruction = 32'hFFFFFFFF; if_valid = 1'b1;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_illegal !== 1'b1) $display("FAIL ill_flag got %b want 1", id_ex_illegal); else passed++;
        checks++; if (id_ex_valid !== 1'b1) $display("FAIL ill_valid got %b want 1", id_ex_valid); else passed++;
        checks++; if (id_ex_reg_write !== 1'b0 || id_ex_mem_write !== 1'b0 || id_ex_mem_read !== 1'b0)
            $display("FAIL ill_ctrl got rw=%b mw=%b mr=%b want 0 0 0", id_ex_reg_write, id_ex_mem_write, id_ex_mem_read);
        else passed++;
    endtask

    task automatic test_reset_mid_stall();
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        tick();
        wb_we = 1'b0;
        if_instruction = I_ADD31; if_valid = 1'b1;
        tick();
        checks++; if (id_ex_rs1_data !== 32'h55) $display("FAIL rst_x1_before got %h want 55", id_ex_rs1_data); else passed++;
        if_instruction = I_LW;
        tick();
        if_instruction = I_ADD;
        #1;
        checks++; if (stall_if !== 1'b1) $display("FAIL rst_stall_before got %b want 1", stall_if); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (stall_if !== 1'b0) $display("FAIL rst_stall_after got %b want 0", stall_if); else passed++;
        checks++; if (id_ex_valid !== 1'b0 || id_ex_mem_read !== 1'b0) $display("FAIL rst_ctrl got v=%b mr=%b want 0 0", id_ex_valid, id_ex_mem_read); else passed++;
        checks++; if (id_ex_rd !== 5'd0 || id_ex_imm !== 32'h0 || id_ex_pc !== 30'd0)
            $display("FAIL rst_fields got rd=%0d imm=%h pc=%0d want 0 0 0", id_ex_rd, id_ex_imm, id_ex_pc);
        else passed++;
        if_instruction = I_ADD31;
        tick();
        if_valid = 1'b0;
        checks++; if (id_ex_rs1_data !== 32'h0) $display("FAIL rst_x1_cleared got %h want 0", id_ex_rs1_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_regfile();
        test_immediates();
        test_flush_over_stall();
        test_illegal();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
